// File: rtl/systolic_pkg.sv
`default_nettype none
// ============================================================================
// systolic_pkg : shared types and helpers for the systolic result drain
// Revision 1.0
// ============================================================================
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE_S    = 3'b001,
        CAPTURE_S = 3'b010,
        DRAIN_S   = 3'b100
    } drain_state_e;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/drain_counter.sv
`default_nettype none
// ============================================================================
// drain_counter : saturating element counter with terminal-count flag at N-1
// Revision 1.0
// ============================================================================
module drain_counter #(
    parameter int N_P  = 4,
    parameter int CW_P = 2
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            en_i,
    input  logic            inc_i,
    input  logic            clr_i,
    output logic [CW_P-1:0] count_o,
    output logic            tc_o
);

    logic [CW_P-1:0] count_q;
    logic [CW_P-1:0] count_d;

    assign tc_o    = (count_q == CW_P'(N_P - 1));
    assign count_o = count_q;

    // Saturates at N-1 so the index can never leave the valid element range.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            if (clr_i) begin
                count_d = '0;
            end else if (inc_i && !tc_o) begin
                count_d = count_q + CW_P'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_result_drain.sv
`default_nettype none
// ============================================================================
// systolic_result_drain : snapshots all MAC results, streams them row-major
// Revision 1.0
// ============================================================================
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int width_p        = 32,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2
) (
    input  logic                                                      clk_i,
    input  logic                                                      reset_ni,
    input  logic                                                      en_i,
    input  logic [width_p*array_width_p*array_height_p-1:0]           z_i,
    input  logic [array_width_p*array_height_p-1:0]                   z_valid_i,
    output logic [array_width_p*array_height_p-1:0]                   z_yumi_o,
    output logic                                                      valid_o,
    input  logic                                                      yumi_i,
    output logic [width_p-1:0]                                        data_o,
    output logic [idx_width(array_width_p*array_height_p)-1:0]        index_o,
    output logic                                                      last_o
);

    localparam int N  = array_width_p * array_height_p;
    localparam int IW = idx_width(N);

    drain_state_e state_q;
    drain_state_e state_d;

    logic [IW-1:0]      count_q;
    logic               tc;
    logic               cnt_inc;
    logic               cnt_clr;
    logic [width_p-1:0] snap_q [N];
    logic [width_p-1:0] data_mux;

    always_comb begin
        state_d = state_q;
        cnt_inc = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            IDLE_S: begin
                if (&z_valid_i) begin
                    state_d = CAPTURE_S;
                end
            end
            CAPTURE_S: begin
                state_d = DRAIN_S;
                cnt_clr = 1'b1;
            end
            DRAIN_S: begin
                if (yumi_i) begin
                    if (tc) begin
                        state_d = IDLE_S;
                        cnt_clr = 1'b1;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_d = IDLE_S;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE_S;
        end else if (en_i) begin
            state_q <= state_d;
        end
    end

    drain_counter #(
        .N_P  (N),
        .CW_P (IW)
    ) u_counter (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .en_i     (en_i),
        .inc_i    (cnt_inc),
        .clr_i    (cnt_clr),
        .count_o  (count_q),
        .tc_o     (tc)
    );

    // The array holds its results until acked, so the one-cycle capture is safe.
    for (genvar k = 0; k < N; k++) begin : g_snap
        always_ff @(posedge clk_i or negedge reset_ni) begin
            if (!reset_ni) begin
                snap_q[k] <= '0;
            end else if (en_i && (state_q == CAPTURE_S)) begin
                snap_q[k] <= z_i[k*width_p +: width_p];
            end
        end
    end

    always_comb begin
        data_mux = '0;
        for (int k = 0; k < N; k++) begin
            if (count_q == IW'(k)) begin
                data_mux = snap_q[k];
            end
        end
    end

    assign z_yumi_o = {N{(state_q == CAPTURE_S) && en_i}};
    assign valid_o  = (state_q == DRAIN_S);
    assign data_o   = data_mux;
    assign index_o  = count_q;
    assign last_o   = valid_o && tc;

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_drain.sv
`default_nettype none
// ============================================================================
// tb_systolic_result_drain : scoreboard bench for the 2x2 result drain
// Revision 1.0
// ============================================================================
module tb_systolic_result_drain;

    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_ni = 1'b0;
    logic           en_i = 1'b1;
    logic [W*N-1:0] z_i = '0;
    logic [N-1:0]   z_valid_i = '0;
    logic [N-1:0]   z_yumi_o;
    logic           valid_o;
    logic           yumi_i = 1'b0;
    logic [W-1:0]   data_o;
    logic [1:0]     index_o;
    logic           last_o;

    typedef struct packed {
        logic [W-1:0] data;
        logic [1:0]   idx;
        logic         last;
    } exp_t;

    exp_t exp_q [$];
    int total = 0;
    int bad   = 0;
    int xfers = 0;

    always #5 clk = ~clk;

    systolic_result_drain #(
        .width_p        (W),
        .array_width_p  (2),
        .array_height_p (2)
    ) dut (
        .clk_i     (clk),
        .reset_ni  (reset_ni),
        .en_i      (en_i),
        .z_i       (z_i),
        .z_valid_i (z_valid_i),
        .z_yumi_o  (z_yumi_o),
        .valid_o   (valid_o),
        .yumi_i    (yumi_i),
        .data_o    (data_o),
        .index_o   (index_o),
        .last_o    (last_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each qualified transfer and checks hold stability.
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data;
    logic [1:0]   prev_idx;
    always @(negedge clk) begin
        if (!reset_ni) begin
            prev_hold = 1'b0;
        end else begin
            if (yumi_i && !valid_o) check("illegal_yumi", 1, 0);
            if (valid_o) begin
                if (prev_hold) begin
                    check("hold_data", data_o, prev_data);
                    check("hold_index", index_o, prev_idx);
                end
                if (yumi_i && en_i) begin
                    xfers++;
                    prev_hold = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_xfer", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("data", data_o, e.data);
                        check("index", index_o, e.idx);
                        check("last", last_o, e.last);
                    end
                end else begin
                    prev_hold = 1'b1;
                    prev_data = data_o;
                    prev_idx  = index_o;
                end
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] d0, d1, d2, d3);
        z_i = {d3, d2, d1, d0};
    endtask

    // Raises all valids, checks the one-cycle ack, ends with the DUT in DRAIN.
    task automatic start_capture(input logic [W-1:0] d0, d1, d2, d3);
        exp_t e;
        load(d0, d1, d2, d3);
        z_valid_i = 4'b1111;
        tick();
        check("z_yumi_capture", z_yumi_o, 4'b1111);
        check("valid_in_capture", valid_o, 0);
        z_valid_i = 4'b0000;
        tick();
        check("z_yumi_after", z_yumi_o, 4'b0000);
        check("valid_drain", valid_o, 1);
        check("first_index", index_o, 0);
        e.data = d0; e.idx = 2'd0; e.last = 1'b0; exp_q.push_back(e);
        e.data = d1; e.idx = 2'd1; e.last = 1'b0; exp_q.push_back(e);
        e.data = d2; e.idx = 2'd2; e.last = 1'b0; exp_q.push_back(e);
        e.data = d3; e.idx = 2'd3; e.last = 1'b1; exp_q.push_back(e);
    endtask

    task automatic drain(input logic [7:0] pat);
        int i;
        for (i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            yumi_i = pat[i % 8];
            tick();
        end
        yumi_i = 1'b0;
        check("drain_complete", exp_q.size(), 0);
        check("valid_after_drain", valid_o, 0);
    endtask

    initial begin
        int x0;
        // Reset held with full valids and random data
        z_i = {$urandom, $urandom, $urandom, $urandom};
        z_valid_i = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst_valid", valid_o, 0);
            check("rst_zyumi", z_yumi_o, 0);
            check("rst_data", data_o, 0);
            check("rst_last", last_o, 0);
        end
        z_valid_i = 4'b0000;
        reset_ni = 1'b1;
        tick();

        // Basic drain, yumi always high
        start_capture(32'h11, 32'h22, 32'h33, 32'h44);
        x0 = xfers;
        drain(8'hFF);
        check("basic_xfers", xfers - x0, 4);

        // Backpressure pattern 0,0,1,0,1,1,0,1 (bit i = cycle i)
        start_capture(32'h11, 32'h22, 32'h33, 32'h44);
        x0 = xfers;
        drain(8'b1011_0100);
        check("bp_xfers", xfers - x0, 4);

        // Partial valid must not start a capture
        z_valid_i = 4'b0111;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("partial_zyumi", z_yumi_o, 0);
            check("partial_valid", valid_o, 0);
        end
        start_capture(32'hA1, 32'hB2, 32'hC3, 32'hD4);
        z_i = {N*W{1'b1}};
        drain(8'hFF);

        // en_i stall mid-drain
        start_capture(32'h5, 32'h6, 32'h7, 32'h8);
        yumi_i = 1'b1;
        tick();
        en_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_index", index_o, 1);
            check("stall_data", data_o, 32'h6);
            check("stall_zyumi", z_yumi_o, 0);
        end
        en_i = 1'b1;
        drain(8'hFF);

        // Async reset between edges after element 1
        start_capture(32'h9, 32'hA, 32'hB, 32'hC);
        yumi_i = 1'b1;
        tick();
        tick();
        yumi_i = 1'b0;
        #2;
        reset_ni = 1'b0;
        #1;
        check("async_valid", valid_o, 0);
        check("async_data", data_o, 0);
        check("async_index", index_o, 0);
        exp_q.delete();
        tick();
        reset_ni = 1'b1;
        tick();
        check("post_rst_valid", valid_o, 0);
        start_capture(32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003, 32'hDEAD0004);
        drain(8'hFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
